lp_down_sample_pack: RTL and testbench
======================================

LP_DOWN_SAMPLE_PACK -- requirements
Module: lp_down_sample_pack

Interface
REQ-001 The block SHALL have parameter TCQ, default 0.1, meaning the simulation clock-to-Q delay on every register assignment.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of one filtered sample.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of packed output words buffered (power of two, at least 2).
REQ-004 The block SHALL have port clk_i  input  1  the single clock; all logic is in this domain.
REQ-005 The block SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port laser_start_i  input  1  run enable; high = RUN.
REQ-007 The block SHALL have port fir_down_sample_num_i  input  8  decimation parameter 0~19; keep 1 of every num+1 samples.
REQ-008 The block SHALL have port lp_laser_vld_i  input  1  filtered sample strobe; no backpressure on this port.
REQ-009 The block SHALL have port lp_laser_data_i  input  DATA_WIDTH  filtered sample.
REQ-010 The block SHALL have port m_tvalid_o  output  1  packed word valid.
REQ-011 The block SHALL have port m_tready_i  input  1  downstream ready.
REQ-012 The block SHALL have port m_tdata_o  output  2*DATA_WIDTH  packed word; first kept sample in [DATA_WIDTH-1:0], second kept sample in the upper half.
REQ-013 The block SHALL have port overflow_o  output  1  sticky flag: a packed word was dropped because the FIFO was full.
REQ-014 The block SHALL have port word_cnt_o  output  32  number of words pushed into the FIFO during the current run.

Function
REQ-015 The block SHALL have two states: IDLE (laser_start_i low) and RUN; IDLE->RUN on laser_start_i rising, RUN->IDLE on laser_start_i falling, both taking effect at the next clock edge.
REQ-016 On IDLE->RUN the block SHALL latch N = min(fir_down_sample_num_i, 19) and clear the decimation counter, the half-word flag, overflow_o and word_cnt_o; N SHALL NOT change during RUN.
REQ-017 In RUN, each lp_laser_vld_i SHALL advance the decimation counter 0..N with wrap to 0; the sample SHALL be kept only when the counter is 0 before advancing.
REQ-018 A kept sample SHALL go to the low half-word register when the half flag is 0 (flag->1); otherwise it SHALL form a word {sample, low half} pushed to the FIFO on the next edge (flag->0).
REQ-019 Latency from the second kept sample's strobe edge to m_tvalid_o high SHALL be 2 cycles when the FIFO is empty.
REQ-020 Output handshake: a word transfers on any edge with m_tvalid_o and m_tready_i both high; m_tdata_o SHALL hold stable while m_tvalid_o is high and m_tready_i is low.
REQ-021 If a push coincides with a transfer while the FIFO is full, the push SHALL succeed.
REQ-022 If a push occurs while the FIFO is full with no transfer, the word SHALL be dropped, overflow_o set, and word_cnt_o not incremented.
REQ-023 word_cnt_o SHALL increment by 1 per successful push and saturate at 0xFFFFFFFF.
REQ-024 On RUN->IDLE, a held partial half-word SHALL be discarded and counters cleared; FIFO content SHALL be retained and keep draining; overflow_o and word_cnt_o SHALL hold.
REQ-025 In IDLE, lp_laser_vld_i SHALL be ignored.
REQ-026 With N=0, every sample SHALL be kept.

Reset
REQ-027 While rst_i is high, regardless of clock, the block SHALL force IDLE, m_tvalid_o=0, m_tdata_o=0, overflow_o=0, word_cnt_o=0, FIFO empty, and all counters and the half flag to 0.
REQ-028 Reset asserted mid-run SHALL discard FIFO content; after release the block SHALL be in IDLE until a new laser_start_i rising edge is seen.

Verification
REQ-029 The bench SHALL cover: num=0, start high, samples 0x0001..0x0004, ready=1 -> words 0x00020001, 0x00040003; word_cnt_o=2.
REQ-030 The bench SHALL cover: num=2, samples 1..12 -> samples 1,4,7,10 kept; words 0x00040001, 0x000A0007.
REQ-031 The bench SHALL cover: num=25 -> behaves as N=19; 40 samples give exactly 1 word {21,1}.
REQ-032 The bench SHALL cover: num=0, ready=0, 10 samples with FIFO_DEPTH=4 -> 4 words held, 5th word dropped, overflow_o=1, word_cnt_o=4; ready=1 -> first 4 words drain in order.
REQ-033 The bench SHALL cover: num=0, 3 samples then start low -> 1 word output, sample 3 discarded; restart -> overflow_o=0, word_cnt_o=0.
REQ-034 The bench SHALL cover: rst_i pulsed asynchronously between clock edges while m_tvalid_o=1 -> m_tvalid_o=0 immediately, with all outputs at their reset values.

Source files
------------

// File: rtl/lp_down_sample_pack.sv
// Decimates a filtered sample stream, packs kept sample pairs into 2*DATA_WIDTH
// words and buffers them in a small FIFO with a valid/ready output.
module lp_down_sample_pack #(
  parameter real TCQ        = 0.1,
  parameter int  DATA_WIDTH = 16,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    laser_start_i,
  input  logic [7:0]              fir_down_sample_num_i,
  input  logic                    lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0]   lp_laser_data_i,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic [2*DATA_WIDTH-1:0] m_tdata_o,
  output logic                    overflow_o,
  output logic [31:0]             word_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] N_MAX = 5'd19;

  generate
    if (TCQ < 0.0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("lp_down_sample_pack: TCQ must be >= 0 and FIFO_DEPTH a power of two >= 2");
    end
  endgenerate

  function automatic logic [4:0] clamp_num(input logic [7:0] num);
    return (num > 8'd19) ? N_MAX : num[4:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e state_q, state_d;
  logic   start_prev_q;
  logic   start_rise, start_fall;

  logic [4:0]              n_q, n_d;
  logic [4:0]              dec_cnt_q, dec_cnt_d;
  logic                    half_q, half_d;
  logic [DATA_WIDTH-1:0]   low_q, low_d;
  logic                    push_q, push_d;
  logic [2*DATA_WIDTH-1:0] word_q, word_d;
  logic                    overflow_q, overflow_d;
  logic [31:0]             word_cnt_q, word_cnt_d;

  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    fifo_empty, fifo_full, pop, push_ok;

  // State register; start_prev resets high so a start held through reset is not a new run
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_prev_q <= laser_start_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (laser_start_i && !start_prev_q) state_d = RUN;
      RUN:     if (!laser_start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_rise = (state_q == IDLE) && (state_d == RUN);
    start_fall = (state_q == RUN) && (state_d == IDLE);
  end

  // Decimation and half-word packing
  always_comb begin
    n_d       = n_q;
    dec_cnt_d = dec_cnt_q;
    half_d    = half_q;
    low_d     = low_q;
    push_d    = 1'b0;
    word_d    = word_q;
    if (start_rise) begin
      n_d       = clamp_num(fir_down_sample_num_i);
      dec_cnt_d = '0;
      half_d    = 1'b0;
    end else if (state_q != RUN || start_fall) begin
      dec_cnt_d = '0;
      half_d    = 1'b0;
    end else if (lp_laser_vld_i) begin
      dec_cnt_d = (dec_cnt_q >= n_q) ? 5'd0 : dec_cnt_q + 5'd1;
      if (dec_cnt_q == 5'd0) begin
        if (!half_q) begin
          low_d  = lp_laser_data_i;
          half_d = 1'b1;
        end else begin
          word_d = {lp_laser_data_i, low_q};
          push_d = 1'b1;
          half_d = 1'b0;
        end
      end
    end
  end

  // Output FIFO; a push into a full FIFO succeeds only when a pop frees a slot on the same edge
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && m_tready_i;
    push_ok    = push_q && (!fifo_full || pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    word_cnt_d = word_cnt_q;
    if (start_rise) begin
      overflow_d = 1'b0;
      word_cnt_d = '0;
    end else begin
      if (push_q && !push_ok) overflow_d = 1'b1;
      if (push_ok) word_cnt_d = sat_inc(word_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q        <= '0;
      dec_cnt_q  <= '0;
      half_q     <= 1'b0;
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      n_q        <= n_d;
      dec_cnt_q  <= dec_cnt_d;
      half_q     <= half_d;
      push_q     <= push_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    low_q  <= low_d;
    word_q <= word_d;
    if (push_ok) mem_q[wr_ptr_q] <= word_q;
  end

  // Data is gated by the empty flag so the output reads zero in and after reset
  assign m_tvalid_o = !fifo_empty;
  assign m_tdata_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_lp_down_sample_pack.sv
// Directed bench for lp_down_sample_pack: decimation, packing, backpressure,
// overflow, stop/restart and asynchronous reset.
module tb_lp_down_sample_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num;
  logic        vld;
  logic [15:0] data;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        overflow;
  logic [31:0] word_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] got_q[$];

  lp_down_sample_pack #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .laser_start_i         (start),
    .fir_down_sample_num_i (num),
    .lp_laser_vld_i        (vld),
    .lp_laser_data_i       (data),
    .m_tvalid_o            (tvalid),
    .m_tready_i            (tready),
    .m_tdata_o             (tdata),
    .overflow_o            (overflow),
    .word_cnt_o            (word_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a handshake seen at negedge completes at the next posedge
  always @(negedge clk) begin
    if (!rst && tvalid && tready) got_q.push_back(tdata);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    vld  = 1'b1;
    data = d;
    tick(1);
    vld  = 1'b0;
  endtask

  task automatic run_begin(input logic [7:0] n);
    num   = n;
    start = 1'b1;
    tick(1);
  endtask

  task automatic run_end();
    start = 1'b0;
    tick(6);
    got_q.delete();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    num    = 8'd0;
    vld    = 1'b0;
    data   = '0;
    tready = 1'b1;
    tick(2);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", word_cnt, 0);
    rst = 1'b0;
    tick(2);

    // num=0: every sample kept, 2-cycle latency to tvalid
    run_begin(8'd0);
    send(16'd1);
    send(16'd2);
    check("lat_before", tvalid, 0);
    send(16'd3);
    check("lat_after", tvalid, 1);
    check("lat_data", tdata, 32'h0002_0001);
    send(16'd4);
    tick(4);
    check("n0_size", got_q.size(), 2);
    check("n0_w0", got_at(0), 32'h0002_0001);
    check("n0_w1", got_at(1), 32'h0004_0003);
    check("n0_cnt", word_cnt, 2);
    run_end();

    // num=2: keep 1,4,7,10
    run_begin(8'd2);
    for (int i = 1; i <= 12; i++) send(16'(i));
    tick(4);
    check("n2_size", got_q.size(), 2);
    check("n2_w0", got_at(0), 32'h0004_0001);
    check("n2_w1", got_at(1), 32'h000A_0007);
    check("n2_cnt", word_cnt, 2);
    run_end();

    // num=25 clamps to 19: keep 1 and 21
    run_begin(8'd25);
    for (int i = 1; i <= 40; i++) send(16'(i));
    tick(4);
    check("n25_size", got_q.size(), 1);
    check("n25_w0", got_at(0), 32'h0015_0001);
    check("n25_cnt", word_cnt, 1);
    run_end();

    // Backpressure: 5 words into a 4-deep FIFO, last one dropped
    tready = 1'b0;
    run_begin(8'd0);
    for (int i = 1; i <= 10; i++) send(16'(i));
    tick(3);
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", word_cnt, 4);
    check("ovf_tvalid", tvalid, 1);
    check("ovf_hold", tdata, 32'h0002_0001);
    tready = 1'b1;
    tick(8);
    check("ovf_size", got_q.size(), 4);
    check("ovf_w0", got_at(0), 32'h0002_0001);
    check("ovf_w1", got_at(1), 32'h0004_0003);
    check("ovf_w2", got_at(2), 32'h0006_0005);
    check("ovf_w3", got_at(3), 32'h0008_0007);
    check("ovf_empty", tvalid, 0);
    start = 1'b0;
    tick(6);
    check("idle_ovf_hold", overflow, 1);
    check("idle_cnt_hold", word_cnt, 4);
    got_q.delete();

    // Stop mid-pair discards sample 3; restart clears flags
    run_begin(8'd0);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    start = 1'b0;
    tick(5);
    check("stop_size", got_q.size(), 1);
    check("stop_w0", got_at(0), 32'h0002_0001);
    check("stop_cnt", word_cnt, 1);
    send(16'd9);
    send(16'd9);
    tick(4);
    check("idle_ignore", got_q.size(), 1);
    run_begin(8'd0);
    check("restart_ovf", overflow, 0);
    check("restart_cnt", word_cnt, 0);
    send(16'd4);
    send(16'd5);
    tick(4);
    check("restart_size", got_q.size(), 2);
    check("restart_w", got_at(1), 32'h0005_0004);
    got_q.delete();

    // Asynchronous reset mid-cycle while a word is pending
    tready = 1'b0;
    send(16'd1);
    send(16'd2);
    tick(3);
    check("pre_rst_tvalid", tvalid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tdata", tdata, 0);
    check("arst_ovf", overflow, 0);
    check("arst_cnt", word_cnt, 0);
    tick(1);
    rst    = 1'b0;
    tready = 1'b1;
    send(16'd7);
    send(16'd8);
    tick(4);
    check("post_rst_tvalid", tvalid, 0);
    check("post_rst_cnt", word_cnt, 0);
    check("post_rst_size", got_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
